// File: rtl/word_s2p_rx.sv
// Serial receive end of the word link: recovers byte alignment from idle characters
// and extracts SOF-framed 32-bit words from an MSB-first bit stream.
module word_s2p_rx #(
  parameter int         DATA_W     = 32,
  parameter logic [7:0] IDLE       = 8'hBC,
  parameter logic [7:0] SOF        = 8'h7C,
  parameter int         SYNC_COUNT = 4
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              ENB,
  input  logic              serial_in,
  output logic [DATA_W-1:0] DATO,
  output logic              VALID,
  output logic              active,
  output logic              sync_err
);

  localparam int BYTES = DATA_W / 8;
  localparam int BI_W  = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int IC_W  = $clog2(SYNC_COUNT + 1);

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    ALIGN   = 2'd1,
    IDLE_ST = 2'd2,
    DATA    = 2'd3
  } state_t;

  state_t            state, state_nxt;
  logic [7:0]        sh, sh_next;
  logic [2:0]        bit_cnt, bit_cnt_nxt;
  logic [IC_W-1:0]   idle_cnt, idle_cnt_nxt;
  logic [BI_W-1:0]   byte_idx, byte_idx_nxt;
  logic [DATA_W-1:0] word, word_nxt;
  logic [DATA_W-1:0] dato_nxt;
  logic              valid_nxt;
  logic              serr_nxt;
  logic              active_nxt;
  logic              boundary;

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state    <= HUNT;
      sh       <= '0;
      bit_cnt  <= '0;
      idle_cnt <= '0;
      byte_idx <= '0;
      word     <= '0;
      DATO     <= '0;
      VALID    <= 1'b0;
      active   <= 1'b0;
      sync_err <= 1'b0;
    end else if (ENB) begin
      state    <= state_nxt;
      sh       <= sh_next;
      bit_cnt  <= bit_cnt_nxt;
      idle_cnt <= idle_cnt_nxt;
      byte_idx <= byte_idx_nxt;
      word     <= word_nxt;
      DATO     <= dato_nxt;
      VALID    <= valid_nxt;
      active   <= active_nxt;
      sync_err <= serr_nxt;
    end else begin
      VALID    <= 1'b0;
      sync_err <= 1'b0;
    end
  end

  // All byte decisions look at the byte completed by the bit arriving this edge.
  always_comb begin
    sh_next      = {sh[6:0], serial_in};
    boundary     = (bit_cnt == 3'd7);
    state_nxt    = state;
    bit_cnt_nxt  = bit_cnt + 3'd1;
    idle_cnt_nxt = idle_cnt;
    byte_idx_nxt = byte_idx;
    word_nxt     = word;
    dato_nxt     = DATO;
    valid_nxt    = 1'b0;
    serr_nxt     = 1'b0;

    case (state)
      HUNT: begin
        bit_cnt_nxt = '0;
        if (sh_next == IDLE) begin
          idle_cnt_nxt = IC_W'(1);
          state_nxt    = ALIGN;
        end
      end

      ALIGN: begin
        if (boundary) begin
          if (sh_next == IDLE) begin
            idle_cnt_nxt = idle_cnt + IC_W'(1);
            if (idle_cnt == IC_W'(SYNC_COUNT - 1))
              state_nxt = IDLE_ST;
          end else begin
            idle_cnt_nxt = '0;
            state_nxt    = HUNT;
          end
        end
      end

      IDLE_ST: begin
        if (boundary) begin
          if (sh_next == SOF) begin
            byte_idx_nxt = '0;
            state_nxt    = DATA;
          end else if (sh_next != IDLE) begin
            serr_nxt     = 1'b1;
            idle_cnt_nxt = '0;
            state_nxt    = HUNT;
          end
        end
      end

      DATA: begin
        // Payload bytes are taken verbatim, even if they look like IDLE or SOF.
        if (boundary) begin
          word_nxt     = {word[DATA_W-9:0], sh_next};
          byte_idx_nxt = byte_idx + BI_W'(1);
          if (byte_idx == BI_W'(BYTES - 1)) begin
            dato_nxt  = {word[DATA_W-9:0], sh_next};
            valid_nxt = 1'b1;
            state_nxt = IDLE_ST;
          end
        end
      end

      default: state_nxt = HUNT;
    endcase

    active_nxt = (state_nxt == IDLE_ST) || (state_nxt == DATA);
  end

endmodule

// File: tb/tb_word_s2p_rx.sv
// Directed bench for word_s2p_rx: expected words and latencies are queued as frames
// are sent and checked when VALID appears.
module tb_word_s2p_rx;

  logic        CLK = 1'b0;
  logic        reset = 1'b1;
  logic        ENB = 1'b0;
  logic        serial_in = 1'b0;
  logic [31:0] DATO;
  logic        VALID;
  logic        active;
  logic        sync_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int valid_cnt = 0;
  int serr_cnt = 0;

  typedef struct {
    logic [31:0] w;
    int          lat;
    int          start;
  } exp_t;

  exp_t sb[$];

  word_s2p_rx dut (
    .CLK      (CLK),
    .reset    (reset),
    .ENB      (ENB),
    .serial_in(serial_in),
    .DATO     (DATO),
    .VALID    (VALID),
    .active   (active),
    .sync_err (sync_err)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Output monitor on the falling edge, away from the sampling edge.
  always @(negedge CLK) begin
    exp_t e;
    if (sync_err === 1'b1) serr_cnt++;
    if (VALID === 1'b1) begin
      valid_cnt++;
      if (sb.size() == 0) begin
        check("valid_unexpected", 32'(VALID), 32'd0);
      end else begin
        e = sb.pop_front();
        check("dato", DATO, e.w);
        check("latency", 32'(cyc - e.start), 32'(e.lat));
      end
    end
  end

  task automatic send_bit(input logic b);
    serial_in = b;
    @(posedge CLK);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic send_frame(input logic [31:0] w, input int stall_at, input int stall_len);
    exp_t e;
    e.w     = w;
    e.lat   = 40 + ((stall_at >= 0) ? stall_len : 0);
    e.start = cyc;
    sb.push_back(e);
    send_byte(8'h7C);
    for (int i = 31; i >= 0; i--) begin
      if ((31 - i) == stall_at) begin
        ENB = 1'b0;
        serial_in = ~w[i];
        for (int k = 0; k < stall_len; k++) begin
          @(posedge CLK);
          #1;
          check("stall_valid", 32'(VALID), 32'd0);
          check("stall_active", 32'(active), 32'd1);
        end
        ENB = 1'b1;
      end
      send_bit(w[i]);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    int v0;
    logic [2:0] rbits;

    #1 reset = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_dato", DATO, 32'd0);
    check("rst_valid", 32'(VALID), 32'd0);
    check("rst_active", 32'(active), 32'd0);
    check("rst_sync_err", 32'(sync_err), 32'd0);
    reset = 1'b1;
    ENB = 1'b1;

    // Sync and single frame
    repeat (3) send_byte(8'hBC);
    check("t1_active_pre", 32'(active), 32'd0);
    send_byte(8'hBC);
    check("t1_active_rise", 32'(active), 32'd1);
    repeat (2) send_byte(8'hBC);
    send_frame(32'h01234567, -1, 0);
    send_byte(8'hBC);
    check("t1_valid_cnt", 32'(valid_cnt), 32'd1);
    check("t1_dato", DATO, 32'h01234567);

    // Reserved values inside data, back-to-back frames
    send_frame(32'hBC7CBC7C, -1, 0);
    send_frame(32'h76543210, -1, 0);
    send_byte(8'hBC);
    check("t3_valid_cnt", 32'(valid_cnt), 32'd3);
    check("t3_dato", DATO, 32'h76543210);

    // Loss of sync
    s0 = serr_cnt;
    send_byte(8'h55);
    check("t4_sync_err", 32'(sync_err), 32'd1);
    check("t4_active_fall", 32'(active), 32'd0);
    send_bit(1'b1);
    check("t4_sync_err_pulse", 32'(sync_err), 32'd0);
    send_bit(1'b0);
    repeat (3) send_byte(8'hBC);
    check("t4_active_pre", 32'(active), 32'd0);
    send_byte(8'hBC);
    check("t4_active_rise", 32'(active), 32'd1);
    send_frame(32'hFEDCBA98, -1, 0);
    send_byte(8'hBC);
    check("t4_serr_cnt", 32'(serr_cnt - s0), 32'd1);
    check("t4_dato", DATO, 32'hFEDCBA98);

    // ENB stall in the middle of byte 2
    v0 = valid_cnt;
    send_frame(32'h092B4D6F, 20, 5);
    send_byte(8'hBC);
    check("t5_valid_cnt", 32'(valid_cnt - v0), 32'd1);
    check("t5_dato", DATO, 32'h092B4D6F);

    // Reset mid-frame
    v0 = valid_cnt;
    send_byte(8'h7C);
    send_byte(8'h12);
    send_byte(8'h34);
    reset = 1'b0;
    #1;
    check("t6_rst_dato", DATO, 32'd0);
    check("t6_rst_active", 32'(active), 32'd0);
    check("t6_rst_valid", 32'(VALID), 32'd0);
    check("t6_rst_sync_err", 32'(sync_err), 32'd0);
    @(posedge CLK);
    #1;
    reset = 1'b1;
    send_byte(8'h56);
    send_byte(8'h78);
    repeat (4) send_byte(8'hBC);
    check("t6_active_resync", 32'(active), 32'd1);
    check("t6_dato_held0", DATO, 32'd0);
    check("t6_no_valid", 32'(valid_cnt - v0), 32'd0);
    send_frame(32'h81A3C5E7, -1, 0);
    send_byte(8'hBC);
    check("t6_dato", DATO, 32'h81A3C5E7);

    // Misaligned start after a fresh reset
    reset = 1'b0;
    @(posedge CLK);
    #1;
    reset = 1'b1;
    s0 = serr_cnt;
    v0 = valid_cnt;
    rbits = 3'($urandom_range(0, 7));
    for (int i = 2; i >= 0; i--) send_bit(rbits[i]);
    repeat (5) send_byte(8'hBC);
    check("t2_active", 32'(active), 32'd1);
    send_frame(32'h89ABCDEF, -1, 0);
    send_byte(8'hBC);
    check("t2_dato", DATO, 32'h89ABCDEF);
    check("t2_valid_cnt", 32'(valid_cnt - v0), 32'd1);
    check("t2_no_sync_err", 32'(serr_cnt - s0), 32'd0);

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/word_s2p_rx.md
# word_s2p_rx

Serial receive end of the word link. It takes the MSB-first bit stream produced by the word serializer at the bit clock and recovers byte alignment from idle characters. It then extracts framed 32-bit words and presents each one as `DATO`, qualified by a one-cycle `VALID` pulse. It sits between the serial line and the parallel-side consumer that the stimulus/check bench observes.

## Interface
- `IDLE`, 8'hBC, idle/alignment character, sent between frames.
- `SOF`, 8'h7C, start-of-frame character; exactly 4 data bytes follow.
- `SYNC_COUNT`, 4, number of consecutive aligned `IDLE` bytes needed to declare sync (≥2).

- `CLK`  in  1  bit clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `ENB`  in  1  enable; when low, the block freezes and ignores `serial_in`.
- `serial_in`  in  1  serial data, sampled on every enabled rising edge of `CLK`, MSB of each byte first.
- `DATO`  out  32  last received word; byte 0 after `SOF` is `DATO[31:24]`.
- `VALID`  out  1  one-cycle pulse; `DATO` is new and stable this cycle.
- `active`  out  1  high while the block is in sync (states IDLE_ST or DATA).
- `sync_err`  out  1  one-cycle pulse when sync is lost.

## Operation
- Shift register: `sh_next = {sh[6:0], serial_in}`. All byte decisions use `sh_next`, the byte completed at this edge.
- bit_cnt (3 bits) marks byte boundaries once aligned; it wraps 7→0.
- States:
  - **HUNT**: compare `sh_next` against `IDLE` on every bit.
    - On a match: bit_cnt←0 (boundary established), idle_cnt←1, go to ALIGN.
  - **ALIGN**: at each byte boundary:
    - `sh_next==IDLE`: idle_cnt++. When idle_cnt reaches `SYNC_COUNT`, go to IDLE_ST.
    - Any other byte: go to HUNT, idle_cnt←0. No `sync_err`, because sync was not yet held.
  - **IDLE_ST**: at each byte boundary:
    - `IDLE`: stay.
    - `SOF`: byte_idx←0, go to DATA.
    - Any other byte: pulse `sync_err`, go to HUNT.
  - **DATA**: at each byte boundary, word ← `{word[23:0], sh_next}` and byte_idx++.
    - On the 4th byte: `DATO` ← completed word, pulse `VALID`, go to IDLE_ST.
    - Data bytes are taken verbatim, including values equal to `IDLE` or `SOF`.
- Back-to-back frames (`SOF` immediately after the 4th data byte, no idle between) are accepted.
- `ENB` low: `sh`, counters, state and `DATO` hold; `VALID` and `sync_err` are 0.

## Timing
- Reset (asynchronous, `reset`=0): state HUNT, `sh`=0, bit_cnt=0, idle_cnt=0, byte_idx=0, word=0, `DATO`=32'h0, `VALID`=0, `active`=0, `sync_err`=0.
- `VALID` and the new `DATO` are registered at the edge that samples the last bit (LSB of byte 3). Both are visible for the following cycle.
- Latency from the first bit of `SOF` to `VALID` high: 40 `CLK` cycles.
- `DATO` holds its value until the next `VALID`.
- `active` is registered: it rises on the edge that accepts the `SYNC_COUNT`-th idle, and falls on the edge that enters HUNT.
- Reset asserted mid-frame aborts the partial word. After release, the block resyncs from HUNT and `DATO` stays 0 until the next complete frame.
- Minimum time to sync from HUNT: 8×`SYNC_COUNT` cycles of aligned idles, counted from the first idle bit.

## Test plan
- **Sync and single frame.** Drive 6×8'hBC, then 8'h7C, then 01 23 45 67, then 8'hBC.
  - `active` rises after the 4th BC.
  - `VALID` pulses once, 40 cycles after the 7C starts.
  - `DATO`=32'h01234567.
- **Misaligned start.** Drive 3 random bits, then 5×BC, then frame 89 AB CD EF.
  - Alignment is found.
  - `DATO`=32'h89ABCDEF with one `VALID`.
  - No `sync_err`.
- **Reserved values inside data.** Drive frame BC 7C BC 7C, then back-to-back frame 76 54 32 10 with no idle between.
  - Two `VALID` pulses, 40 cycles apart.
  - `DATO` sequence 32'hBC7CBC7C, then 32'h76543210.
- **Loss of sync.** While synced in IDLE_ST, drive byte 8'h55.
  - `sync_err` pulses once and `active` falls.
  - After 4 BC plus frame FE DC BA 98: `DATO`=32'hFEDCBA98.
- **ENB stall.** Drop `ENB` for 5 cycles in the middle of byte 2 of frame 09 2B 4D 6F, and pause the serial source with it.
  - `DATO`=32'h092B4D6F.
  - `VALID` pulses exactly once, 5 cycles later than nominal.
- **Reset mid-frame.** Pulse `reset` low after byte 1 of a frame.
  - All outputs return to 0 at once.
  - No `VALID` for the aborted frame.
  - Resync and frame 81 A3 C5 E7 give `DATO`=32'h81A3C5E7.
